// File: rtl/cg_counter_mod.sv
// cg_counter_mod: modulo up/down counter with variable step, terminal-count pulse and sticky overflow.
// Saturation (i_sat) is built only when CG_COUNTER_SAT_EN is defined; otherwise the counter always wraps.
module cg_counter_mod #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_prst,
    input  logic                  i_stop,
    input  logic                  i_dir,
    input  logic [STEP_WIDTH-1:0] i_step,
    input  logic [DATA_WIDTH-1:0] i_default,
    input  logic [DATA_WIDTH-1:0] i_limit,
    input  logic                  i_sat,
    input  logic                  i_clr_ovf,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_tc,
    output logic                  o_ovf,
    output logic                  o_zero
);
    localparam int XW = DATA_WIDTH + 1;

    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  tc_q, tc_d, ovf_q, ovf_d;
    logic [XW-1:0]         cnt_x, stp_x, lim_x, mod_x, sum_x, dif_x;
    logic [XW-1:0]         up_raw, dn_raw, up_wrap, dn_wrap, up_ev, dn_ev, cnt_nx;
    logic                  step_nz, up_hit, dn_hit, event_w, cnt_en;

    // One extra bit keeps count+step and count+modulus free of overflow
    assign cnt_x   = {1'b0, count_q};
    assign stp_x   = XW'(i_step);
    assign lim_x   = {1'b0, i_limit};
    assign mod_x   = lim_x + XW'(1);
    assign sum_x   = cnt_x + stp_x;
    assign dif_x   = cnt_x - stp_x;
    assign up_raw  = sum_x - mod_x;
    assign dn_raw  = cnt_x + mod_x - stp_x;
    assign up_wrap = (up_raw > lim_x) ? '0 : up_raw;
    assign dn_wrap = (dn_raw > lim_x) ? '0 : dn_raw;

`ifdef CG_COUNTER_SAT_EN
    logic unused_w;
    assign up_ev    = i_sat ? lim_x : up_wrap;
    assign dn_ev    = i_sat ? '0 : dn_wrap;
    assign unused_w = cnt_nx[DATA_WIDTH];
`else
    logic unused_w;
    assign up_ev    = up_wrap;
    assign dn_ev    = dn_wrap;
    assign unused_w = cnt_nx[DATA_WIDTH] ^ i_sat;
`endif

    // A zero step never moves the count, so it can never raise an event
    assign step_nz = |i_step;
    assign up_hit  = step_nz & (sum_x > lim_x);
    assign dn_hit  = step_nz & (cnt_x < stp_x);
    assign event_w = i_dir ? dn_hit : up_hit;
    assign cnt_nx  = i_dir ? (dn_hit ? dn_ev : dif_x) : (up_hit ? up_ev : sum_x);
    assign cnt_en  = !i_prst && !i_stop;

    always_comb begin
        count_d = i_prst ? i_default : (cnt_en ? cnt_nx[DATA_WIDTH-1:0] : count_q);
        tc_d    = cnt_en & event_w;
        ovf_d   = i_prst ? ovf_q : ((cnt_en & event_w) | (ovf_q & ~i_clr_ovf));
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = tc_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = (count_q == '0);
endmodule

// File: tb/tb_cg_counter_mod.sv
// tb_cg_counter_mod: directed bench for cg_counter_mod with an arithmetic reference model
// compared every cycle, plus hand-computed literal checks.
module tb_cg_counter_mod;
    logic        i_clk = 1'b0;
    logic        i_rstn, i_prst, i_stop, i_dir, i_sat, i_clr_ovf;
    logic [7:0]  i_step;
    logic [31:0] i_default, i_limit;
    logic [31:0] o_count;
    logic        o_tc, o_ovf, o_zero;

    int n_checks = 0;
    int n_fail   = 0;

    cg_counter_mod dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_prst(i_prst), .i_stop(i_stop), .i_dir(i_dir),
        .i_step(i_step), .i_default(i_default), .i_limit(i_limit), .i_sat(i_sat),
        .i_clr_ovf(i_clr_ovf), .o_count(o_count), .o_tc(o_tc), .o_ovf(o_ovf), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

`ifdef CG_COUNTER_SAT_EN
    wire sat_eff = i_sat;
`else
    wire sat_eff = 1'b0;
`endif

    // Reference: plain signed arithmetic on the count range 0..limit
    function automatic logic [32:0] model_step(longint c, longint st, longint l, bit dn, bit sat);
        longint r;
        bit ev;
        ev = 0;
        if (st == 0) r = c;
        else if (!dn) begin
            if (c + st <= l) r = c + st;
            else begin
                ev = 1;
                r = sat ? l : c + st - (l + 1);
                if (r > l) r = 0;
            end
        end else begin
            if (c >= st) r = c - st;
            else begin
                ev = 1;
                r = sat ? 0 : c + (l + 1) - st;
                if (r > l || r < 0) r = 0;
            end
        end
        return {ev, r[31:0]};
    endfunction

    logic [31:0] m_count;
    logic        m_tc, m_ovf;
    wire  [32:0] m_nxt = model_step(longint'(m_count), longint'(i_step), longint'(i_limit), i_dir, sat_eff);

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            m_count <= 0;
            m_tc    <= 0;
            m_ovf   <= 0;
        end else if (i_prst) begin
            m_count <= i_default;
            m_tc    <= 0;
        end else if (i_stop) begin
            m_tc    <= 0;
            m_ovf   <= m_ovf & ~i_clr_ovf;
        end else begin
            m_count <= m_nxt[31:0];
            m_tc    <= m_nxt[32];
            m_ovf   <= m_nxt[32] | (m_ovf & ~i_clr_ovf);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        chk("model_count", 64'(o_count), 64'(m_count));
        chk("model_tc", 64'(o_tc), 64'(m_tc));
        chk("model_ovf", 64'(o_ovf), 64'(m_ovf));
        chk("model_zero", 64'(o_zero), 64'(m_count == 0));
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic [31:0] c, input logic tc, input logic ovf);
        chk({tag, "_count"}, 64'(o_count), 64'(c));
        chk({tag, "_tc"}, 64'(o_tc), 64'(tc));
        chk({tag, "_ovf"}, 64'(o_ovf), 64'(ovf));
        chk({tag, "_zero"}, 64'(o_zero), 64'(c == 0));
    endtask

    initial begin
        i_rstn = 0; i_prst = 0; i_stop = 0; i_dir = 0; i_sat = 0; i_clr_ovf = 0;
        i_step = 1; i_default = 0; i_limit = 9;
        tick(); tick();
        lit("reset", 0, 0, 0);
        i_rstn = 1;
        // Up wrap 1..9 then 0
        for (int i = 1; i <= 10; i++) begin
            tick();
            lit("upwrap", 32'(i % 10), i == 10, i == 10);
        end
        repeat (7) tick();
        lit("pre_async", 7, 0, 1);
        #2 i_rstn = 0;
        #1 lit("async_rst", 0, 0, 0);
        tick();
        i_rstn = 1;
        // Down wrap with step 3
        i_prst = 1; i_default = 1;
        tick();
        lit("preset1", 1, 0, 0);
        i_prst = 0; i_dir = 1; i_step = 3;
        tick(); lit("dnwrap", 8, 1, 1);
        tick(); lit("dnstep", 5, 0, 1);
        // Sticky overflow clear vs set
        i_clr_ovf = 1;
        tick(); lit("clr_noev", 2, 0, 0);
        tick(); lit("clr_ev", 9, 1, 1);
        tick(); lit("clr_after", 6, 0, 0);
        i_clr_ovf = 0;
        // Saturation
        i_prst = 1; i_default = 8; i_dir = 0; i_step = 4; i_sat = 1;
        tick();
        lit("preset8", 8, 0, 0);
        i_prst = 0;
`ifdef CG_COUNTER_SAT_EN
        tick(); lit("sat1", 9, 1, 1);
        tick(); lit("sat2", 9, 1, 1);
`else
        tick(); lit("nosat1", 2, 1, 1);
        tick(); lit("nosat2", 6, 0, 1);
`endif
        i_sat = 0;
        // Preset over stop, then stop hold, then out-of-range up event
        i_prst = 1; i_stop = 1; i_default = 32'h0404_0202;
        tick(); lit("prst_stop", 32'h0404_0202, 0, 1);
        i_prst = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); lit("hold", 32'h0404_0202, 0, 1);
        end
        i_stop = 0; i_limit = 32'h0000_FFFF; i_step = 1;
        tick(); lit("oor_up", 0, 1, 1);
        // Zero step never counts nor fires
        i_limit = 9; i_step = 0; i_clr_ovf = 1;
        tick(); lit("step0", 0, 0, 0);
        i_clr_ovf = 0; i_dir = 1;
        tick(); lit("step0_dn", 0, 0, 0);
        // Above-limit count: down subtracts plainly, up is an event
        i_prst = 1; i_default = 20;
        tick();
        i_prst = 0; i_step = 3;
        tick(); lit("oor_dn", 17, 0, 0);
        i_dir = 0;
        tick(); lit("oor_up2", 0, 1, 1);
        // Mixed directed sweep, checked against the model each cycle
        for (int i = 0; i < 30; i++) begin
            i_step = 8'(i % 5);
            i_dir = ((i / 3) % 2) == 1;
            i_limit = 32'(5 + i % 4);
            i_sat = (i % 7) == 0;
            i_clr_ovf = (i % 6) == 5;
            tick();
        end
        @(negedge i_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
